// File: rtl/ram_pkg.sv
// Shared types and constants for the ram_if memory responder.
package ram_pkg;

    localparam int RAM_WORD_W = 32;
    // LAT is at most 15, so four bits of wait counter are enough.
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        FREE   = 2'b00,
        BUSY   = 2'b01,
        ACCESS = 2'b10,
        ERROR  = 2'b11
    } ramstate_t;

endpackage

// File: rtl/ram_array.sv
// Single-port synchronous word array; read data is registered when re is high and holds otherwise.
module ram_array #(
    parameter int WORD_W = 32,
    parameter int DEPTH  = 1024
) (
    input  logic                     CLK,
    input  logic                     rst,
    input  logic                     we,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [WORD_W-1:0]        wdata,
    output logic [WORD_W-1:0]        rdata
);

    logic [WORD_W-1:0] mem [DEPTH];

    // Contents are never cleared; only the read register sees reset.
    always_ff @(posedge CLK) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/ram_responder.sv
// Latency-accurate word RAM responder for the ram_if protocol (FREE/BUSY/ACCESS/ERROR handshake).
// Define RAM_MISALIGN_ERR_EN to flag requests with ramaddr[1:0] != 0 as ERROR.
module ram_responder
    import ram_pkg::*;
#(
    parameter int WORD_W = RAM_WORD_W,
    parameter int DEPTH  = 1024,
    parameter int LAT    = 2
) (
    input  logic              CLK,
    input  logic              rst,
    input  logic              ramREN,
    input  logic              ramWEN,
    input  logic [WORD_W-1:0] ramaddr,
    input  logic [WORD_W-1:0] ramstore,
    output logic [WORD_W-1:0] ramload,
    output ramstate_t         ramstate
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] LAST = (LAT == 0) ? '0 : CNT_W'(LAT - 1);

    logic              req_any;
    logic              req_both;
    logic              out_of_range;
    logic              misaligned;
    logic              bad_req;
    logic              legal_req;
    logic              changed;
    logic              eval_free;
    logic              go_access;
    logic              ren_q;
    logic              wen_q;
    logic [WORD_W-1:0] addr_q;
    logic [WORD_W-1:0] store_q;
    logic [CNT_W-1:0]  cnt;

    assign req_any      = ramREN | ramWEN;
    assign req_both     = ramREN & ramWEN;
    assign out_of_range = |(ramaddr >> (AW + 2));

`ifdef RAM_MISALIGN_ERR_EN
    assign misaligned = |ramaddr[1:0];
`else
    assign misaligned = 1'b0;
`endif

    assign bad_req   = req_any & (req_both | out_of_range | misaligned);
    assign legal_req = req_any & ~bad_req;

    assign changed = (ramREN != ren_q) || (ramWEN != wen_q) ||
                     (ramaddr != addr_q) || (ramstore != store_q);

    // An aborted BUSY access is re-evaluated exactly like a fresh request in FREE.
    assign eval_free = (ramstate == FREE) || ((ramstate == BUSY) && changed);

    // The array is driven from the live inputs: on the commit edge they either equal the
    // latched request (BUSY, unchanged) or are the request being accepted (LAT == 0).
    assign go_access = !rst && legal_req &&
                       ((eval_free && (LAT == 0)) ||
                        ((ramstate == BUSY) && !changed && (cnt == LAST)));

    ram_array #(
        .WORD_W (WORD_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .CLK    (CLK),
        .rst    (rst),
        .we     (go_access & ramWEN),
        .re     (go_access & ramREN),
        .addr   (ramaddr[AW+1:2]),
        .wdata  (ramstore),
        .rdata  (ramload)
    );

    always_ff @(posedge CLK) begin
        if (eval_free && legal_req) begin
            ren_q   <= ramREN;
            wen_q   <= ramWEN;
            addr_q  <= ramaddr;
            store_q <= ramstore;
        end
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            ramstate <= FREE;
            cnt      <= '0;
        end else if (eval_free) begin
            cnt <= '0;
            if (bad_req) begin
                ramstate <= ERROR;
            end else if (legal_req) begin
                ramstate <= (LAT == 0) ? ACCESS : BUSY;
            end else begin
                ramstate <= FREE;
            end
        end else begin
            case (ramstate)
                BUSY: begin
                    if (cnt == LAST) begin
                        ramstate <= ACCESS;
                        cnt      <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ACCESS:  ramstate <= FREE;
                ERROR:   if (!bad_req) ramstate <= FREE;
                default: ramstate <= FREE;
            endcase
        end
    end

endmodule

// File: doc/ram_responder.md
Name: ram_responder

Overview:
- Memory-side responder for the ram_if request protocol: accepts ramREN/ramWEN/ramaddr/ramstore from an initiator (core or testbench mux) and returns ramload plus a ramstate handshake.
- Models a word-addressed RAM with a configurable number of wait states.
- Serves as a drop-in latency-accurate memory model at the far end of the core-to-memory path.

Parameters:
- WORD_W, 32, data and address width in bits.
- DEPTH, 1024, number of words; must be a power of two.
- LAT, 2, wait-state cycles spent in BUSY before ACCESS; legal range 0..15.

Ports:
- CLK  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- ramREN  in  1  read request, level, held by the initiator.
- ramWEN  in  1  write request, level, held by the initiator.
- ramaddr  in  WORD_W  byte address.
- ramstore  in  WORD_W  write data.
- ramload  out  WORD_W  read data, registered.
- ramstate  out  2  ramstate_t: FREE, BUSY, ACCESS, ERROR.

Behaviour:
- Reset:
  - Interface: one clock, CLK; reset is synchronous and active-high (rst). rst high at an edge forces ramstate=FREE, ramload=0 and wait counter=0.
  - Array contents are not cleared.
  - Reset mid-BUSY abandons the access; no write commits.
- Word index: ramaddr[log2(DEPTH)+1:2].
- Out of range: address >= DEPTH*4 raises ERROR.
- Request: exactly one of REN/WEN high. Both high is illegal.
- FREE:
  - Legal request → latch addr, store and op; counter=0; go BUSY, or go ACCESS directly if LAT=0.
  - Illegal or out-of-range request → ERROR.
  - No request → stay in FREE.
- BUSY:
  - Counter increments each cycle. When counter==LAT-1 → ACCESS.
  - Any change of REN, WEN, ramaddr or ramstore versus the latched values aborts the access.
  - After an abort, re-evaluate as in FREE in the same cycle. Counter restarts at 0; nothing is written.
- Entering ACCESS:
  - Read: ramload <= mem[index].
  - Write: mem[index] <= latched store; ramload unchanged.
  - ACCESS lasts exactly 1 cycle, then → FREE unconditionally.
- Throughput and ramload:
  - A request still held in FREE starts a new access, so back-to-back accesses take LAT+2 cycles each.
  - ramload holds its last read value until the next read ACCESS.
- ERROR:
  - Stays while the offending condition persists.
  - → FREE on the first cycle it is gone; the next request is accepted from FREE.
- Read-after-write to the same word in consecutive accesses returns the new data.
- Initiator-visible latency from request assertion in FREE to ACCESS: LAT+1 edges.

Optional Feature:
- RAM_MISALIGN_ERR_EN defined: ramaddr[1:0]!=0 on a request → ERROR, no access.
- Undefined: ramaddr[1:0] ignored; access goes to the containing word.

Decomposition:
- ram_pkg holds:
  - ramstate_t (FREE=2'b00, BUSY=2'b01, ACCESS=2'b10, ERROR=2'b11);
  - word-width constant;
  - an internal state enum if it differs from ramstate_t.
- Sub-module ram_array:
  - single-port synchronous word array, DEPTH x WORD_W;
  - inputs: we, addr, wdata; output: rdata registered on the read-enable edge.
- The FSM, counter and compare logic stay in ram_responder.

Test Plan:
- Reset mid-BUSY:
  - Assert rst during BUSY of a write 0xDEADBEEF to 0x40.
  - Expect ramstate=FREE and ramload=0 next edge; a later read of 0x40 does not return 0xDEADBEEF.
- Write then read, LAT=2:
  - Write 0x12345678 to 0x10: FREE→BUSY,BUSY→ACCESS at edge 3.
  - Read 0x10 yields ramload=0x12345678 at its ACCESS edge.
- LAT=0:
  - Read 0x8 after writing 0xA5A5A5A5.
  - Expect ACCESS on the first edge after the request and ramload=0xA5A5A5A5.
- Abort:
  - Change ramaddr from 0x20 to 0x24 during BUSY.
  - Counter restarts; ACCESS occurs LAT+1 edges after the change; word 0x20 is unmodified.
- Errors:
  - REN=WEN=1 → ERROR; drop WEN → FREE, then normal read.
  - Address 0x1000 with DEPTH=1024 → ERROR.
- Misalignment:
  - With RAM_MISALIGN_ERR_EN, read 0x13 → ERROR.
  - Without it, read 0x13 returns word 0x10.
